conversor_binario_bcd: RTL and testbench

Sequential signed-binary-to-BCD converter that turns the 16-bit two's-complement Booth product into the 21-bit sign-plus-five-digit code consumed by `display_7segmentos`. It sits between the multiplier output and the display. It accepts one product per request, runs a 16-step shift-and-add-3 (double dabble) sequence, then updates a held output register the display reads continuously. The display keeps the last converted value until a new conversion completes.

---
 rtl/conversor_binario_bcd.sv | 92 +++++++++
 tb/tb_conversor_binario_bcd.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/conversor_binario_bcd.sv
`timescale 1ns/1ps
// Signed 16-bit two's-complement to sign + 5-digit BCD converter (double dabble).
// The output register only changes on completion or reset, so the display never sees partial results.
//
// state    | meaning
// INACTIVO | idle, waiting for valido
// DESPLAZA | 16 add-3/shift steps on {scratch, magnitude}
// FIN      | publish {sign, scratch}, pulse listo
module conversor_binario_bcd (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] producto,
   input  logic        valido,
   output logic [20:0] codigo_BCD,
   output logic        listo,
   output logic        ocupado
);

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      DESPLAZA = 2'd1,
      FIN      = 2'd2
   } t_estado;

   t_estado     r_estado;
   logic [15:0] r_mag;
   logic        r_signo;
   logic [19:0] r_scratch;
   logic [3:0]  r_cnt;
   logic [20:0] r_codigo;
   logic        r_listo;

   logic [15:0] w_mag;
   logic [19:0] w_adj;
   logic [35:0] w_desp;

   // 0x8000 negates to itself, which read as unsigned is the wanted 32768.
   assign w_mag = producto[15] ? (~producto + 16'd1) : producto;

   always_comb begin
      w_adj = r_scratch;
      for (int d = 0; d < 5; d++) begin
         if (r_scratch[d*4 +: 4] >= 4'd5)
            w_adj[d*4 +: 4] = r_scratch[d*4 +: 4] + 4'd3;
      end
   end

   assign w_desp = {w_adj, r_mag} << 1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado  <= INACTIVO;
         r_mag     <= '0;
         r_signo   <= 1'b0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_codigo  <= '0;
         r_listo   <= 1'b0;
      end else begin
         r_listo <= 1'b0;
         case (r_estado)
            INACTIVO: begin
               if (valido) begin
                  r_mag     <= w_mag;
                  r_signo   <= producto[15];
                  r_scratch <= '0;
                  r_cnt     <= '0;
                  r_estado  <= DESPLAZA;
               end
            end
            DESPLAZA: begin
               r_scratch <= w_desp[35:16];
               r_mag     <= w_desp[15:0];
               r_cnt     <= r_cnt + 4'd1;
               if (r_cnt == 4'd15)
                  r_estado <= FIN;
            end
            FIN: begin
               r_codigo <= {r_signo, r_scratch};
               r_listo  <= 1'b1;
               r_estado <= INACTIVO;
            end
            default: r_estado <= INACTIVO;
         endcase
      end
   end

   assign codigo_BCD = r_codigo;
   assign listo      = r_listo;
   assign ocupado    = (r_estado != INACTIVO);

endmodule

// File: tb/tb_conversor_binario_bcd.sv
`timescale 1ns/1ps
// Self-checking bench for conversor_binario_bcd: directed cases plus a random sweep
// compared against a decimal-arithmetic reference model.
module tb_conversor_binario_bcd;

   logic        clk;
   logic        reset;
   logic [15:0] producto;
   logic        valido;
   logic [20:0] codigo_BCD;
   logic        listo;
   logic        ocupado;

   int checks;
   int errors;

   conversor_binario_bcd dut (
      .clk        (clk),
      .reset      (reset),
      .producto   (producto),
      .valido     (valido),
      .codigo_BCD (codigo_BCD),
      .listo      (listo),
      .ocupado    (ocupado)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
      end
   endtask

   function automatic logic [20:0] modelo(input logic [15:0] p);
      int v;
      int m;
      logic [20:0] r;
      v = $signed(p);
      m = (v < 0) ? -v : v;
      r[20]    = (v < 0);
      r[19:16] = 4'((m / 10000) % 10);
      r[15:12] = 4'((m / 1000) % 10);
      r[11:8]  = 4'((m / 100) % 10);
      r[7:4]   = 4'((m / 10) % 10);
      r[3:0]   = 4'(m % 10);
      return r;
   endfunction

   // Waits (bounded) for listo after the current point; n = edges waited.
   task automatic esperar_listo(output int n, output int busy, output bit estable);
      logic [20:0] prev;
      prev = codigo_BCD;
      n = 0;
      busy = 0;
      estable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (ocupado) busy++;
         if (listo) break;
         if (codigo_BCD !== prev) estable = 1'b0;
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Called #1 after a clock edge with the block idle.
   task automatic convertir(input string tag, input logic [15:0] p);
      int n;
      int busy;
      bit estable;
      producto = p;
      valido   = 1'b1;
      @(posedge clk); #1;
      valido   = 1'b0;
      producto = 16'($urandom);
      esperar_listo(n, busy, estable);
      chk({tag, " latency"}, n, 17);
      chk({tag, " busy"}, busy, 17);
      chk({tag, " stable"}, 32'(estable), 1);
      chk({tag, " code"}, 32'(codigo_BCD), 32'(modelo(p)));
      @(posedge clk); #1;
      chk({tag, " pulse"}, 32'(listo), 0);
   endtask

   initial begin
      int n;
      int busy;
      int nlisto;
      bit estable;
      logic [15:0] lim [5];

      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      producto = '0;
      valido   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst code", 32'(codigo_BCD), 0);
      chk("rst listo", 32'(listo), 0);
      chk("rst busy", 32'(ocupado), 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      convertir("zero", 16'h0000);
      chk("zero exact", 32'(codigo_BCD), 32'h000000);
      convertir("12345", 16'h3039);
      chk("12345 exact", 32'(codigo_BCD), 32'h012345);
      convertir("-1", 16'hFFFF);
      chk("-1 exact", 32'(codigo_BCD), 32'h100001);

      lim = '{16'h8000, 16'h4000, 16'h7FFF, 16'h8001, 16'h0009};
      foreach (lim[i]) convertir($sformatf("lim%0d", i), lim[i]);
      convertir("min", 16'h8000);
      chk("min exact", 32'(codigo_BCD), 32'h132768);

      // Request while busy is ignored; request in the listo cycle is taken.
      producto = 16'h0001;
      valido   = 1'b1;
      @(posedge clk); #1;
      valido   = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      producto = 16'h0002;
      valido   = 1'b1;
      @(posedge clk); #1;
      valido   = 1'b0;
      esperar_listo(n, busy, estable);
      chk("ign latency", n, 12);
      chk("ign code", 32'(codigo_BCD), 32'h000001);
      producto = 16'h0063;
      valido   = 1'b1;
      @(posedge clk); #1;
      valido   = 1'b0;
      chk("b2b pulse", 32'(listo), 0);
      chk("b2b busy", 32'(ocupado), 1);
      esperar_listo(n, busy, estable);
      chk("b2b latency", n, 17);
      chk("b2b code", 32'(codigo_BCD), 32'h000099);
      @(posedge clk); #1;

      // Reset in the middle of a conversion.
      convertir("pre", 16'h3039);
      producto = 16'hFFFF;
      valido   = 1'b1;
      @(posedge clk); #1;
      valido   = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort code", 32'(codigo_BCD), 0);
      chk("abort busy", 32'(ocupado), 0);
      chk("abort listo", 32'(listo), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      nlisto = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (listo) nlisto++;
      end
      chk("abort nolisto", nlisto, 0);
      chk("abort hold", 32'(codigo_BCD), 0);
      convertir("1111", 16'h0457);
      chk("1111 exact", 32'(codigo_BCD), 32'h001111);

      for (int i = 0; i < 1000; i++)
         convertir($sformatf("rnd%0d", i), 16'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
